// File: rtl/parity_frame_pkg.sv
// Shared types and constants for the parity/CRC frame receive controller.
//   state_t            : controller FSM states
//   CRC8_POLY_DEFAULT  : default CRC-8 polynomial (x^8 + x^2 + x + 1)
//   CRC8_INIT_DEFAULT  : default CRC register start value
//   ERR_CNT_W          : width of the saturating error-frame counter
package parity_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;
  localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/crc8_step.sv
// Combinational CRC-8 update for one byte, MSB first, no reflection.
//   i_crc  : current CRC register
//   i_data : byte being folded in
//   o_crc  : CRC register after the byte
module crc8_step
  import parity_frame_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT
) (
  input  logic [7:0] i_crc,
  input  logic [7:0] i_data,
  output logic [7:0] o_crc
);

  logic [7:0] w_stage [0:8];

  assign w_stage[0] = i_crc ^ i_data;

  // One shift/conditional-XOR stage per data bit.
  for (genvar g = 0; g < 8; g++) begin : g_stage
    assign w_stage[g+1] = w_stage[g][7] ? ({w_stage[g][6:0], 1'b0} ^ POLY)
                                        : {w_stage[g][6:0], 1'b0};
  end

  assign o_crc = w_stage[8];

endmodule

// File: rtl/parity_frame_ctrl.sv
// Receive-side frame controller: accepts FRAME_LEN payload bytes plus one CRC
// byte, checks even parity per byte and CRC-8 over the payload, reports a
// status word over a valid/ready handshake and requests bounded retries.
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : synchronous abort back to IDLE
//   in_valid/in_ready : byte handshake; in_data + in_par carry the byte
//   st_valid/st_ready : status handshake
//   frame_ok, par_err, crc_err, give_up : frame status (held while st_valid)
//   retry_req         : one-cycle pulse in the handshake cycle of a retryable error
//   err_count         : saturating count of errored frames
module parity_frame_ctrl
  import parity_frame_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned MAX_RETRY = 3,
  parameter logic [7:0]  CRC_POLY  = CRC8_POLY_DEFAULT,
  parameter logic [7:0]  CRC_INIT  = CRC8_INIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic                 in_par,
  output logic                 st_valid,
  input  logic                 st_ready,
  output logic                 frame_ok,
  output logic                 par_err,
  output logic                 crc_err,
  output logic                 give_up,
  output logic                 retry_req,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned CNT_W   = $clog2(FRAME_LEN + 1);
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_byte_cnt;
  logic [RETRY_W-1:0]   r_retry_cnt;
  logic [7:0]           r_crc;
  logic [7:0]           w_crc_nxt;
  logic                 r_par_acc;
  logic                 w_accept;
  logic                 w_byte_bad;
  logic                 w_par_tot;
  logic                 w_crc_bad;
  logic                 w_handshake;
  logic                 w_last_byte;
  logic                 w_retry_left;
  logic                 w_exhausted;

  crc8_step #(.POLY(CRC_POLY)) u_crc (
    .i_crc  (r_crc),
    .i_data (in_data),
    .o_crc  (w_crc_nxt)
  );

  assign w_accept     = in_valid & in_ready;
  assign w_byte_bad   = ^{in_par, in_data};
  assign w_par_tot    = r_par_acc | w_byte_bad;
  assign w_crc_bad    = (r_crc != in_data);
  assign w_handshake  = st_valid & st_ready;
  assign w_last_byte  = (r_byte_cnt == CNT_W'(FRAME_LEN));
  // retry_cnt never exceeds MAX_RETRY, so equality marks exhaustion.
  assign w_exhausted  = (r_retry_cnt == RETRY_W'(MAX_RETRY));
  assign w_retry_left = ~w_exhausted;

  // Pulse lives in the handshake cycle itself; flush suppresses it.
  assign retry_req = w_handshake & ~frame_ok & w_retry_left & ~flush;

  // Next-state logic; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = RECV;
      RECV:    if (w_accept && w_last_byte) w_state_nxt = REPORT;
      REPORT:  if (w_handshake) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  // State register; handshake flags are registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      in_ready <= 1'b0;
      st_valid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      in_ready <= (w_state_nxt == RECV);
      st_valid <= (w_state_nxt == REPORT);
    end
  end

  // Datapath: byte counting, CRC/parity accumulation, status and retry bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt  <= '0;
      r_retry_cnt <= '0;
      r_crc       <= CRC_INIT;
      r_par_acc   <= 1'b0;
      frame_ok    <= 1'b0;
      par_err     <= 1'b0;
      crc_err     <= 1'b0;
      give_up     <= 1'b0;
      err_count   <= '0;
    end else if (flush) begin
      // Partial frame and status dropped; retry and error history kept.
      r_byte_cnt <= '0;
      r_crc      <= CRC_INIT;
      r_par_acc  <= 1'b0;
      frame_ok   <= 1'b0;
      par_err    <= 1'b0;
      crc_err    <= 1'b0;
      give_up    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_byte_cnt <= '0;
          r_crc      <= CRC_INIT;
          r_par_acc  <= 1'b0;
        end
        RECV: begin
          if (w_accept) begin
            if (!w_last_byte) begin
              r_crc      <= w_crc_nxt;
              r_par_acc  <= w_par_tot;
              r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end else begin
              par_err  <= w_par_tot;
              crc_err  <= w_crc_bad;
              frame_ok <= ~w_par_tot & ~w_crc_bad;
              give_up  <= (w_par_tot | w_crc_bad) & w_exhausted;
            end
          end
        end
        REPORT: begin
          if (w_handshake) begin
            frame_ok <= 1'b0;
            par_err  <= 1'b0;
            crc_err  <= 1'b0;
            give_up  <= 1'b0;
            if (frame_ok) begin
              r_retry_cnt <= '0;
            end else begin
              r_retry_cnt <= w_retry_left ? (r_retry_cnt + RETRY_W'(1)) : '0;
              if (err_count != ERR_MAX) err_count <= err_count + ERR_CNT_W'(1);
            end
          end
        end
        default: begin
          r_byte_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
module tb_parity_frame_ctrl;

  localparam int MAX_RETRY = 3;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_par, st_ready;
  logic [7:0] in_data;
  logic       in_ready, st_valid, frame_ok, par_err, crc_err, give_up, retry_req;
  logic [7:0] err_count;
  logic       z_in_ready, z_st_valid, z_frame_ok, z_par_err, z_crc_err, z_give_up, z_retry_req;
  logic [7:0] z_err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int m_retry = 0;
  int m_err = 0;

  always #5 clk = ~clk;

  parity_frame_ctrl #(.FRAME_LEN(4), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_par(in_par), .st_valid(st_valid), .st_ready(st_ready),
    .frame_ok(frame_ok), .par_err(par_err), .crc_err(crc_err), .give_up(give_up),
    .retry_req(retry_req), .err_count(err_count)
  );

  // Same stimulus, no retry budget: every error must give up immediately.
  parity_frame_ctrl #(.FRAME_LEN(4), .MAX_RETRY(0)) dut_z (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_data(in_data), .in_par(in_par), .st_valid(z_st_valid), .st_ready(st_ready),
    .frame_ok(z_frame_ok), .par_err(z_par_err), .crc_err(z_crc_err), .give_up(z_give_up),
    .retry_req(z_retry_req), .err_count(z_err_count)
  );

  typedef struct {
    logic ok, par, crce, give, rr;
    logic [7:0] err;
  } exp_t;

  typedef struct {
    logic [31:0] pl;
    logic [4:0]  bad;
    logic [7:0]  crc;
    logic ok, par, crce, give, rr;
    logic [7:0]  err;
  } vec_t;

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  // CRC as the remainder of (message * x^8) divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [31:0] pl);
    logic [39:0] msg;
    logic [8:0]  rem;
    msg = {pl, 8'h00};
    rem = 9'h000;
    for (int i = 39; i >= 0; i--) begin
      rem = {rem[7:0], msg[i]};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  task automatic predict(input logic [31:0] pl, input logic [4:0] bad, input logic [7:0] crc,
                         input bit flrep, output exp_t e);
    e.par  = |bad;
    e.crce = (crc_ref(pl) != crc);
    e.ok   = !e.par && !e.crce;
    e.give = !e.ok && (m_retry == MAX_RETRY);
    e.rr   = !e.ok && (m_retry < MAX_RETRY) && !flrep;
    if (!flrep) begin
      if (e.ok) m_retry = 0;
      else begin
        m_retry = (m_retry < MAX_RETRY) ? m_retry + 1 : 0;
        if (m_err < 255) m_err++;
      end
    end
    e.err = 8'(m_err);
  endtask

  task automatic send_byte(input string tag, input logic [7:0] d, input logic bad);
    int n;
    n = 0;
    in_data  = d;
    in_par   = (^d) ^ bad;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s/accept_timeout: in_ready still %0b after %0d cycles", tag, in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [31:0] pl, input logic [4:0] bad,
                           input logic [7:0] crc, input int gap_max, input int bp,
                           input bit hold, input bit flrep, input exp_t e);
    logic [39:0] fr;
    int gap;
    fr = {pl, crc};
    st_ready = hold;
    for (int i = 0; i < 5; i++) begin
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      send_byte(tag, fr[39-8*i -: 8], bad[i]);
    end
    chk(tag, "st_valid", st_valid, 1);
    chk(tag, "in_ready_rep", in_ready, 0);
    chk(tag, "frame_ok", frame_ok, e.ok);
    chk(tag, "par_err", par_err, e.par);
    chk(tag, "crc_err", crc_err, e.crce);
    chk(tag, "give_up", give_up, e.give);
    chk(tag, "z_st_valid", z_st_valid, 1);
    chk(tag, "z_in_ready", z_in_ready, 0);
    chk(tag, "z_frame_ok", z_frame_ok, e.ok);
    chk(tag, "z_par_err", z_par_err, e.par);
    chk(tag, "z_crc_err", z_crc_err, e.crce);
    chk(tag, "z_give_up", z_give_up, !e.ok);
    if (hold) begin
      chk(tag, "retry_req", retry_req, e.rr);
      chk(tag, "z_retry_req", z_retry_req, 0);
    end else begin
      for (int c = 0; c < bp; c++) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
        chk(tag, "bp_st_valid", st_valid, 1);
        chk(tag, "bp_in_ready", in_ready, 0);
        chk(tag, "bp_frame_ok", frame_ok, e.ok);
        chk(tag, "bp_give_up", give_up, e.give);
        chk(tag, "bp_retry_req", retry_req, 0);
      end
      in_valid = 1'b0;
      flush    = flrep;
      st_ready = 1'b1;
      #1;
      chk(tag, "retry_req", retry_req, e.rr);
      chk(tag, "z_retry_req", z_retry_req, 0);
    end
    @(posedge clk); #1;
    flush    = 1'b0;
    st_ready = 1'b0;
    chk(tag, "st_valid_after", st_valid, 0);
    chk(tag, "retry_req_after", retry_req, 0);
    chk(tag, "err_count", err_count, e.err);
    chk(tag, "z_err_count", z_err_count, e.err);
  endtask

  task automatic model_frame(input string tag, input logic [31:0] pl, input logic [4:0] bad,
                             input logic [7:0] crc, input int gap_max, input int bp,
                             input bit hold, input bit flrep);
    exp_t e;
    predict(pl, bad, crc, flrep, e);
    run_frame(tag, pl, bad, crc, gap_max, bp, hold, flrep, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [13];
    exp_t e;
    logic [31:0] pl;
    logic [4:0]  bad;
    logic [7:0]  crc;
    bit          hold, flrep;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_par = 1'b0; in_data = 8'h00; st_ready = 1'b0;

    //         payload       bad      crc    ok    par   crce  give  rr    err
    tbl[0]  = '{32'h00000001, 5'b00000, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{32'h00000001, 5'b00000, 8'h0E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
    tbl[2]  = '{32'h00000001, 5'b00100, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[3]  = '{32'h00000001, 5'b00000, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[4]  = '{32'h00000001, 5'b00000, 8'h0E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3};
    tbl[5]  = '{32'h00000001, 5'b00000, 8'h0E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd4};
    tbl[6]  = '{32'h00000001, 5'b00000, 8'h0E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5};
    tbl[7]  = '{32'h00000001, 5'b00000, 8'h0E, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd6};
    tbl[8]  = '{32'h00000001, 5'b00000, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd6};
    tbl[9]  = '{32'h00000001, 5'b10000, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd7};
    tbl[10] = '{32'h00000001, 5'b00000, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7};
    tbl[11] = '{32'h00000001, 5'b00001, 8'h0E, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd8};
    tbl[12] = '{32'h00000001, 5'b00000, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd8};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset", "in_ready", in_ready, 0);
    chk("reset", "st_valid", st_valid, 0);
    chk("reset", "frame_ok", frame_ok, 0);
    chk("reset", "par_err", par_err, 0);
    chk("reset", "crc_err", crc_err, 0);
    chk("reset", "give_up", give_up, 0);
    chk("reset", "retry_req", retry_req, 0);
    chk("reset", "err_count", err_count, 0);
    rst = 1'b0;

    // Directed table: good/CRC/parity errors, retry exhaustion, recovery
    for (int i = 0; i < 13; i++) begin
      e.ok = tbl[i].ok; e.par = tbl[i].par; e.crce = tbl[i].crce;
      e.give = tbl[i].give; e.rr = tbl[i].rr; e.err = tbl[i].err;
      run_frame($sformatf("tbl%0d", i), tbl[i].pl, tbl[i].bad, tbl[i].crc, 0,
                (i == 1 || i == 3) ? 5 : 0, (i == 8 || i == 12), 1'b0, e);
    end

    // Async reset between edges in the middle of a frame
    send_byte("arst", 8'h00, 1'b0);
    send_byte("arst", 8'h00, 1'b0);
    chk("arst", "in_ready_before", in_ready, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst", "in_ready", in_ready, 0);
    chk("arst", "st_valid", st_valid, 0);
    chk("arst", "err_count", err_count, 0);
    chk("arst", "z_err_count", z_err_count, 0);
    chk("arst", "frame_ok", frame_ok, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_retry = 0; m_err = 0;
    model_frame("arst_good", 32'h00000001, 5'b0, 8'h07, 0, 0, 1'b0, 1'b0);

    // Flush after two payload bytes, then a clean frame
    model_frame("pre_flush_bad", 32'h00000001, 5'b0, 8'h0E, 0, 0, 1'b0, 1'b0);
    send_byte("flush_recv", 8'hA5, 1'b0);
    send_byte("flush_recv", 8'h5A, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_recv", "in_ready", in_ready, 0);
    chk("flush_recv", "st_valid", st_valid, 0);
    chk("flush_recv", "err_count", err_count, 8'(m_err));
    model_frame("post_flush_good", 32'h00000001, 5'b0, 8'h07, 0, 0, 1'b0, 1'b0);

    // Flush colliding with a status handshake: no retry, no count
    model_frame("flush_report", 32'h00000001, 5'b0, 8'h0E, 0, 2, 1'b0, 1'b1);
    model_frame("after_flush_report", 32'h00000001, 5'b0, 8'h0E, 0, 0, 1'b0, 1'b0);

    // Randomized frames against the reference model
    for (int i = 0; i < 60; i++) begin
      pl    = $urandom;
      bad   = ($urandom_range(0, 3) == 0) ? 5'(5'b1 << $urandom_range(0, 4)) : 5'b0;
      crc   = crc_ref(pl);
      if ($urandom_range(0, 2) == 0) crc = crc ^ 8'($urandom_range(1, 255));
      hold  = ($urandom_range(0, 3) == 0);
      flrep = !hold && ($urandom_range(0, 9) == 0);
      model_frame($sformatf("rnd%0d", i), pl, bad, crc, 2, $urandom_range(0, 3), hold, flrep);
    end

    // Drive the error counter into saturation
    for (int i = 0; i < 260; i++) begin
      model_frame($sformatf("sat%0d", i), 32'h00000001, 5'b0, 8'h0E, 0, 0, 1'b1, 1'b0);
    end
    chk("sat_final", "err_count", err_count, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
